multi_word_adder_sequencer: RTL and testbench

Sequential wide-operand adder/subtractor. It accepts two WORDS×32-bit operands through a valid/ready handshake and feeds them one 32-bit slice per cycle, least significant first, through a single combinational 32-bit look-ahead carry adder. The carry from each slice is registered and applied to the next slice. It sits between the register-file/operand fetch stage and the result writeback stage, so wide arithmetic reuses one 32-bit adder instead of a WORDS×32-bit one.

---
 rtl/multi_word_adder_sequencer_pkg.sv | 10 +
 rtl/multi_word_adder_sequencer_lacg.sv | 41 ++++
 rtl/multi_word_adder_sequencer.sv | 94 +++++++++
 tb/tb_multi_word_adder_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/multi_word_adder_sequencer_pkg.sv
// Shared constants for the multi-word adder sequencer: slice width and FSM encodings.
package multi_word_adder_sequencer_pkg;

    localparam int unsigned WORD_WIDTH = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/multi_word_adder_sequencer_lacg.sv
// 32-bit look-ahead carry adder: 4-bit lookahead groups chained by group carries.
module Look_Ahead_Carry_Generator_32_Bit (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Carry_In,
    output logic [31:0] Sum,
    output logic        Carry_Out
);

    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;
    logic [3:0]  gs;
    logic [3:0]  ps;
    logic        ci;

    always_comb begin
        g    = A & B;
        p    = A ^ B;
        c    = '0;
        c[0] = Carry_In;
        gs   = '0;
        ps   = '0;
        ci   = 1'b0;
        for (int unsigned grp = 0; grp < 8; grp++) begin
            gs = g[4*grp +: 4];
            ps = p[4*grp +: 4];
            ci = c[4*grp];
            c[4*grp+1] = gs[0] | (ps[0] & ci);
            c[4*grp+2] = gs[1] | (ps[1] & gs[0]) | (ps[1] & ps[0] & ci);
            c[4*grp+3] = gs[2] | (ps[2] & gs[1]) | (ps[2] & ps[1] & gs[0])
                       | (ps[2] & ps[1] & ps[0] & ci);
            c[4*grp+4] = gs[3] | (ps[3] & gs[2]) | (ps[3] & ps[2] & gs[1])
                       | (ps[3] & ps[2] & ps[1] & gs[0])
                       | (ps[3] & ps[2] & ps[1] & ps[0] & ci);
        end
        Sum       = p ^ c[31:0];
        Carry_Out = c[32];
    end

endmodule

// File: rtl/multi_word_adder_sequencer.sv
// Wide add/subtract over WORDS 32-bit slices, LSB first, through one shared 32-bit adder.
module multi_word_adder_sequencer
    import multi_word_adder_sequencer_pkg::*;
#(
    parameter int unsigned WORDS = 4
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic                        Start_Valid_In,
    output logic                        Start_Ready_Out,
    input  logic [WORD_WIDTH*WORDS-1:0] Data_A_In,
    input  logic [WORD_WIDTH*WORDS-1:0] Data_B_In,
    input  logic                        Carry_In,
    input  logic                        Sub_Mode_In,
    output logic [WORD_WIDTH*WORDS-1:0] Sum_Out,
    output logic                        Carry_Out,
    output logic                        Overflow_Out,
    output logic                        Result_Valid_Out,
    input  logic                        Result_Ready_In
);

    localparam int unsigned W     = WORD_WIDTH * WORDS;
    localparam int unsigned IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    logic [1:0]            state;
    logic [W-1:0]          a_sh;
    logic [W-1:0]          b_sh;
    logic [W-1:0]          result;
    logic                  carry_reg;
    logic [IDX_W-1:0]      idx;
    logic [WORD_WIDTH-1:0] slice_sum;
    logic                  slice_cout;

    Look_Ahead_Carry_Generator_32_Bit u_adder (
        .A         (a_sh[WORD_WIDTH-1:0]),
        .B         (b_sh[WORD_WIDTH-1:0]),
        .Carry_In  (carry_reg),
        .Sum       (slice_sum),
        .Carry_Out (slice_cout)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= ST_IDLE;
            a_sh         <= '0;
            b_sh         <= '0;
            result       <= '0;
            carry_reg    <= 1'b0;
            idx          <= '0;
            Carry_Out    <= 1'b0;
            Overflow_Out <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start_Valid_In) begin
                        a_sh      <= Data_A_In;
                        b_sh      <= Sub_Mode_In ? ~Data_B_In : Data_B_In;
                        carry_reg <= Sub_Mode_In | Carry_In;
                        idx       <= '0;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Operands drain from the bottom while results enter at the top,
                    // so slice 0 ends up in the low word after WORDS steps.
                    result    <= {slice_sum, result[W-1:WORD_WIDTH]};
                    a_sh      <= a_sh >> WORD_WIDTH;
                    b_sh      <= b_sh >> WORD_WIDTH;
                    carry_reg <= slice_cout;
                    idx       <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        Carry_Out    <= slice_cout;
                        Overflow_Out <= (a_sh[WORD_WIDTH-1] == b_sh[WORD_WIDTH-1]) &&
                                        (slice_sum[WORD_WIDTH-1] != a_sh[WORD_WIDTH-1]);
                        idx          <= '0;
                        state        <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (Result_Ready_In) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign Sum_Out          = result;
    assign Start_Ready_Out  = (state == ST_IDLE) && !Reset;
    assign Result_Valid_Out = (state == ST_DONE);

endmodule

// File: tb/tb_multi_word_adder_sequencer.sv
// Directed-vector bench for multi_word_adder_sequencer with WORDS=4.
module tb_multi_word_adder_sequencer;

    localparam int unsigned WORDS = 4;
    localparam int unsigned W     = 32 * WORDS;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] data_a;
    logic [W-1:0] data_b;
    logic         carry_in;
    logic         sub_mode;
    logic [W-1:0] sum_out;
    logic         carry_out;
    logic         overflow_out;
    logic         result_valid;
    logic         result_ready;

    int checks   = 0;
    int failures = 0;

    multi_word_adder_sequencer #(.WORDS(WORDS)) dut (
        .Clock            (clk),
        .Reset            (rst),
        .Start_Valid_In   (start_valid),
        .Start_Ready_Out  (start_ready),
        .Data_A_In        (data_a),
        .Data_B_In        (data_b),
        .Carry_In         (carry_in),
        .Sub_Mode_In      (sub_mode),
        .Sum_Out          (sum_out),
        .Carry_Out        (carry_out),
        .Overflow_Out     (overflow_out),
        .Result_Valid_Out (result_valid),
        .Result_Ready_In  (result_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Accepts one operation, scrambles the inputs afterwards and waits for the result.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub, output int lat);
        @(negedge clk);
        data_a      = a;
        data_b      = b;
        carry_in    = cin;
        sub_mode    = sub;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        data_a      = {$urandom, $urandom, $urandom, $urandom};
        data_b      = {$urandom, $urandom, $urandom, $urandom};
        carry_in    = ~cin;
        sub_mode    = ~sub;
        lat = 0;
        while (!result_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_result(input string tag);
        @(negedge clk);
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        check({tag, "_valid_low"}, W'(result_valid), W'(0));
        check({tag, "_start_ready"}, W'(start_ready), W'(1));
    endtask

    initial begin
        int lat;
        logic [W-1:0] ones;
        logic [W-1:0] held;
        ones         = '1;
        rst          = 1'b1;
        start_valid  = 1'b0;
        data_a       = '0;
        data_b       = '0;
        carry_in     = 1'b0;
        sub_mode     = 1'b0;
        result_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_sum", sum_out, W'(0));
        check("rst_cout", W'(carry_out), W'(0));
        check("rst_ovf", W'(overflow_out), W'(0));
        check("rst_valid", W'(result_valid), W'(0));
        check("rst_ready_in_reset", W'(start_ready), W'(0));
        rst = 1'b0;
        #1;
        check("post_rst_ready", W'(start_ready), W'(1));

        // 1: all-ones + 1
        run_op(ones, W'(1), 1'b0, 1'b0, lat);
        check("t1_latency", W'(lat), W'(4));
        check("t1_sum", sum_out, W'(0));
        check("t1_cout", W'(carry_out), W'(1));
        check("t1_ovf", W'(overflow_out), W'(0));
        check("t1_start_ready_done", W'(start_ready), W'(0));
        release_result("t1");

        // 2: carry crosses slice boundaries
        run_op(128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, W'(0), 1'b1, 1'b0, lat);
        check("t2_sum", sum_out, 128'h0000_0000_0000_0001_0000_0000_0000_0000);
        check("t2_cout", W'(carry_out), W'(0));
        check("t2_ovf", W'(overflow_out), W'(0));
        release_result("t2");

        // 3: subtraction with and without borrow
        run_op(W'(5), W'(7), 1'b1, 1'b1, lat);
        check("t3a_sum", sum_out, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE);
        check("t3a_cout", W'(carry_out), W'(0));
        check("t3a_ovf", W'(overflow_out), W'(0));
        release_result("t3a");
        run_op(W'(7), W'(5), 1'b0, 1'b1, lat);
        check("t3b_sum", sum_out, W'(2));
        check("t3b_cout", W'(carry_out), W'(1));
        check("t3b_ovf", W'(overflow_out), W'(0));
        release_result("t3b");

        // 4: signed overflow both directions
        run_op(128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, W'(1), 1'b0, 1'b0, lat);
        check("t4a_sum", sum_out, 128'h8000_0000_0000_0000_0000_0000_0000_0000);
        check("t4a_ovf", W'(overflow_out), W'(1));
        check("t4a_cout", W'(carry_out), W'(0));
        release_result("t4a");
        run_op(128'h8000_0000_0000_0000_0000_0000_0000_0000, W'(1), 1'b0, 1'b1, lat);
        check("t4b_sum", sum_out, 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF);
        check("t4b_ovf", W'(overflow_out), W'(1));
        check("t4b_cout", W'(carry_out), W'(1));
        release_result("t4b");

        // 5: backpressure while new starts are offered
        run_op(W'(10), W'(20), 1'b0, 1'b0, lat);
        check("t5_sum", sum_out, W'(30));
        held = sum_out;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start_valid = i[0];
            data_a      = W'(1000 + i);
            data_b      = W'(2000 + i);
            @(posedge clk);
            #1;
            check("t5_valid_held", W'(result_valid), W'(1));
            check("t5_start_ready", W'(start_ready), W'(0));
            check("t5_sum_held", sum_out, W'(30));
            check("t5_cout_held", W'(carry_out), W'(0));
        end
        @(negedge clk);
        start_valid = 1'b0;
        release_result("t5");
        check("t5_sum_after", sum_out, held);

        // 6: reset in the middle of RUN
        @(negedge clk);
        data_a      = ones;
        data_b      = ones;
        carry_in    = 1'b1;
        sub_mode    = 1'b0;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("t6_ready_in_reset", W'(start_ready), W'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("t6_sum", sum_out, W'(0));
        check("t6_cout", W'(carry_out), W'(0));
        check("t6_ovf", W'(overflow_out), W'(0));
        check("t6_valid", W'(result_valid), W'(0));
        check("t6_start_ready", W'(start_ready), W'(1));
        run_op(W'(3), W'(4), 1'b0, 1'b0, lat);
        check("t6_latency", W'(lat), W'(4));
        check("t6_sum_after", sum_out, W'(7));
        check("t6_cout_after", W'(carry_out), W'(0));
        release_result("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
